// File: rtl/stream_pkg.sv
// Shared types and constants for the 1-to-2 stream demultiplexer.
// occ_t gives the occupancy states of each per-port 2-entry buffer.
package stream_pkg;
    localparam int BUF_DEPTH  = 2;
    localparam int DEFAULT_CW = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;
endpackage

// File: rtl/stream_demux1to2_fifo2.sv
// Two-entry FIFO with a registered head word.
// A push while FULL is dropped; the parent never issues one.
module fifo2
    import stream_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         push,
    input  logic [N-1:0] din,
    input  logic         pop,
    output logic [N-1:0] dout,
    output logic         valid,
    output logic         full
);
    occ_t         occ, occ_nxt;
    logic [N-1:0] head, head_nxt;
    logic [N-1:0] tail, tail_nxt;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            occ  <= EMPTY;
            head <= '0;
            tail <= '0;
        end else begin
            occ  <= occ_nxt;
            head <= head_nxt;
            tail <= tail_nxt;
        end
    end

    always_comb begin
        occ_nxt  = occ;
        head_nxt = head;
        tail_nxt = tail;
        case (occ)
            EMPTY: begin
                if (push) begin
                    occ_nxt  = ONE;
                    head_nxt = din;
                end
            end
            ONE: begin
                case ({push, pop})
                    2'b10: begin
                        occ_nxt  = FULL;
                        tail_nxt = din;
                    end
                    2'b01: occ_nxt = EMPTY;
                    // Simultaneous push and pop: new word replaces the head.
                    2'b11: head_nxt = din;
                    default: ;
                endcase
            end
            FULL: begin
                if (pop) begin
                    occ_nxt  = ONE;
                    head_nxt = tail;
                end
            end
            default: occ_nxt = EMPTY;
        endcase
    end

    assign dout  = head;
    assign valid = (occ != EMPTY);
    assign full  = (occ == FULL);
endmodule

// File: rtl/stream_demux1to2.sv
// Registered 1-to-2 stream demux: route words by sel into per-port FIFOs.
// Port index 1 is A (sel=1), index 0 is B (sel=0).
module stream_demux1to2
    import stream_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = DEFAULT_CW
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          in_valid,
    input  logic          in_sel,
    input  logic [N-1:0]  in_data,
    output logic          in_ready,
    output logic          a_valid,
    input  logic          a_ready,
    output logic [N-1:0]  a,
    output logic [CW-1:0] a_count,
    output logic          b_valid,
    input  logic          b_ready,
    output logic [N-1:0]  b,
    output logic [CW-1:0] b_count
);
    localparam int PORTS = 2;

    logic [PORTS-1:0]         push, pop, valid, full, rdy;
    logic [PORTS-1:0][N-1:0]  dout;
    logic [PORTS-1:0][CW-1:0] cnt;

    // Readiness looks only at registered full flags, never at consumer ready.
    assign in_ready = rstN & ~full[in_sel];
    assign rdy      = {a_ready, b_ready};

    for (genvar k = 0; k < PORTS; k++) begin : g_port
        assign push[k] = in_valid & in_ready & (in_sel == 1'(k));
        assign pop[k]  = valid[k] & rdy[k];

        fifo2 #(.N(N)) u_fifo (
            .clk  (clk),
            .rstN (rstN),
            .push (push[k]),
            .din  (in_data),
            .pop  (pop[k]),
            .dout (dout[k]),
            .valid(valid[k]),
            .full (full[k])
        );

        always_ff @(posedge clk or negedge rstN) begin
            if (!rstN)       cnt[k] <= '0;
            else if (pop[k]) cnt[k] <= cnt[k] + 1'b1;
        end
    end

    assign a_valid = valid[1];
    assign a       = dout[1];
    assign a_count = cnt[1];
    assign b_valid = valid[0];
    assign b       = dout[0];
    assign b_count = cnt[0];
endmodule

// File: tb/tb_stream_demux1to2.sv
// Directed table plus corner sequences and a randomized scoreboard run.
// A second instance with CW=2 shares the stimulus to exercise counter wrap.
module tb_stream_demux1to2;
    logic clk = 1'b0;
    logic rstN;
    logic in_valid, in_sel, a_ready, b_ready;
    logic [3:0] in_data;
    logic in_ready, a_valid, b_valid;
    logic [3:0] a, b;
    logic [7:0] a_count, b_count;
    logic in_ready2, a_valid2, b_valid2;
    logic [3:0] a2, b2;
    logic [1:0] a_count2, b_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_demux1to2 #(.N(4), .CW(8)) dut (
        .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data),
        .in_ready(in_ready), .a_valid(a_valid), .a_ready(a_ready), .a(a), .a_count(a_count),
        .b_valid(b_valid), .b_ready(b_ready), .b(b), .b_count(b_count)
    );

    stream_demux1to2 #(.N(4), .CW(2)) dut2 (
        .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data),
        .in_ready(in_ready2), .a_valid(a_valid2), .a_ready(a_ready), .a(a2), .a_count(a_count2),
        .b_valid(b_valid2), .b_ready(b_ready), .b(b2), .b_count(b_count2)
    );

    typedef struct {
        logic v, s;
        logic [3:0] d;
        logic ar, br;
        logic ir, av;
        logic [3:0] ea;
        logic bv;
        logic [3:0] eb;
        logic [7:0] ac, bc;
    } vec_t;

    vec_t vt[14];

    function automatic vec_t mk(logic v, logic s, logic [3:0] d, logic ar, logic br,
                                logic ir, logic av, logic [3:0] ea, logic bv, logic [3:0] eb,
                                logic [7:0] ac, logic [7:0] bc);
        vec_t r;
        r.v = v; r.s = s; r.d = d; r.ar = ar; r.br = br;
        r.ir = ir; r.av = av; r.ea = ea; r.bv = bv; r.eb = eb; r.ac = ac; r.bc = bc;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ir, input logic av, input logic [3:0] ea,
                             input logic bv, input logic [3:0] eb, input logic [7:0] ac,
                             input logic [7:0] bc);
        check({tag, " in_ready"}, 32'(in_ready), 32'(ir));
        check({tag, " a_valid"}, 32'(a_valid), 32'(av));
        check({tag, " b_valid"}, 32'(b_valid), 32'(bv));
        if (av) check({tag, " a"}, 32'(a), 32'(ea));
        if (bv) check({tag, " b"}, 32'(b), 32'(eb));
        check({tag, " a_count"}, 32'(a_count), 32'(ac));
        check({tag, " b_count"}, 32'(b_count), 32'(bc));
        check({tag, " a_count cw2"}, 32'(a_count2), 32'(ac & 8'd3));
        check({tag, " b_count cw2"}, 32'(b_count2), 32'(bc & 8'd3));
    endtask

    task automatic drive(input logic v, input logic s, input logic [3:0] d,
                         input logic ar, input logic br);
        in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int qa[$];
        int qb[$];
        int mac, mbc, sent, cyc;
        logic eir;

        //                v  s  d     ar br  ir av a     bv b     ac    bc
        vt[0]  = mk(1, 1, 4'hA, 1, 1, 1, 0, 4'h0, 0, 4'h0, 8'd0, 8'd0);
        vt[1]  = mk(1, 0, 4'h5, 1, 1, 1, 1, 4'hA, 0, 4'h0, 8'd0, 8'd0);
        vt[2]  = mk(0, 0, 4'h0, 1, 1, 1, 0, 4'h0, 1, 4'h5, 8'd1, 8'd0);
        vt[3]  = mk(0, 0, 4'h0, 0, 1, 1, 0, 4'h0, 0, 4'h0, 8'd1, 8'd1);
        vt[4]  = mk(1, 1, 4'h1, 0, 1, 1, 0, 4'h0, 0, 4'h0, 8'd1, 8'd1);
        vt[5]  = mk(1, 1, 4'h2, 0, 1, 1, 1, 4'h1, 0, 4'h0, 8'd1, 8'd1);
        vt[6]  = mk(1, 1, 4'h3, 0, 1, 0, 1, 4'h1, 0, 4'h0, 8'd1, 8'd1);
        vt[7]  = mk(1, 0, 4'h6, 0, 0, 1, 1, 4'h1, 0, 4'h0, 8'd1, 8'd1);
        vt[8]  = mk(1, 0, 4'h7, 0, 1, 1, 1, 4'h1, 1, 4'h6, 8'd1, 8'd1);
        vt[9]  = mk(1, 1, 4'h3, 0, 1, 0, 1, 4'h1, 1, 4'h7, 8'd1, 8'd2);
        vt[10] = mk(1, 1, 4'h3, 1, 1, 0, 1, 4'h1, 0, 4'h0, 8'd1, 8'd3);
        vt[11] = mk(1, 1, 4'h3, 1, 1, 1, 1, 4'h2, 0, 4'h0, 8'd2, 8'd3);
        vt[12] = mk(0, 1, 4'h0, 1, 1, 1, 1, 4'h3, 0, 4'h0, 8'd3, 8'd3);
        vt[13] = mk(0, 1, 4'h0, 1, 1, 1, 0, 4'h0, 0, 4'h0, 8'd4, 8'd3);

        // Power-on reset with a pending word on the input.
        rstN = 1'b0;
        drive(1, 1, 4'hF, 1, 1);
        @(negedge clk);
        @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset a", 32'(a), 32'd0);
        check("reset b", 32'(b), 32'd0);
        check_all("reset", 0, 0, 4'h0, 0, 4'h0, 8'd0, 8'd0);
        in_valid = 1'b0;
        rstN = 1'b1;
        @(posedge clk); #1;
        check_all("post-reset", 1, 0, 4'h0, 0, 4'h0, 8'd0, 8'd0);

        // Routing, back-pressure, port independence, full-plus-pop.
        for (int i = 0; i < 14; i++) begin
            drive(vt[i].v, vt[i].s, vt[i].d, vt[i].ar, vt[i].br);
            @(negedge clk);
            check_all($sformatf("v%0d", i), vt[i].ir, vt[i].av, vt[i].ea, vt[i].bv, vt[i].eb,
                      vt[i].ac, vt[i].bc);
            @(posedge clk); #1;
        end

        // Two more B deliveries bring b_count to 5 (wraps to 1 at CW=2).
        drive(1, 0, 4'h8, 1, 1);
        @(negedge clk); check_all("w0", 1, 0, 4'h0, 0, 4'h0, 8'd4, 8'd3);
        @(posedge clk); #1;
        drive(1, 0, 4'h9, 1, 1);
        @(negedge clk); check_all("w1", 1, 0, 4'h0, 1, 4'h8, 8'd4, 8'd3);
        @(posedge clk); #1;
        drive(0, 0, 4'h0, 1, 1);
        @(negedge clk); check_all("w2", 1, 0, 4'h0, 1, 4'h9, 8'd4, 8'd4);
        @(posedge clk); #1;
        @(negedge clk); check_all("w3", 1, 0, 4'h0, 0, 4'h0, 8'd4, 8'd5);
        check("wrap b_count cw2", 32'(b_count2), 32'd1);
        @(posedge clk); #1;

        // Reset mid-operation flushes both buffered words.
        drive(1, 1, 4'hC, 0, 0);
        @(posedge clk); #1;
        drive(1, 0, 4'hD, 0, 0);
        @(posedge clk); #1;
        check_all("preflush", 1, 1, 4'hC, 1, 4'hD, 8'd4, 8'd5);
        drive(1, 1, 4'hE, 0, 0);
        #1 rstN = 1'b0;
        #1;
        check("flush a", 32'(a), 32'd0);
        check("flush b", 32'(b), 32'd0);
        check_all("flush", 0, 0, 4'h0, 0, 4'h0, 8'd0, 8'd0);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        #1 check("release in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Randomized traffic against a queue scoreboard.
        mac = 0; mbc = 0; sent = 0; cyc = 0;
        while (sent < 1000 && cyc < 20000) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
            @(negedge clk);
            eir = in_sel ? (qa.size() < 2) : (qb.size() < 2);
            check("rnd in_ready", 32'(in_ready), 32'(eir));
            check("rnd a_valid", 32'(a_valid), 32'(qa.size() != 0));
            check("rnd b_valid", 32'(b_valid), 32'(qb.size() != 0));
            if (qa.size() != 0) check("rnd a", 32'(a), 32'(qa[0]));
            if (qb.size() != 0) check("rnd b", 32'(b), 32'(qb[0]));
            check("rnd a_count", 32'(a_count), 32'(mac & 255));
            check("rnd b_count", 32'(b_count), 32'(mbc & 255));
            check("rnd b_count cw2", 32'(b_count2), 32'(mbc & 3));
            if (a_ready && qa.size() != 0) begin void'(qa.pop_front()); mac++; end
            if (b_ready && qb.size() != 0) begin void'(qb.pop_front()); mbc++; end
            if (in_valid && eir) begin
                if (in_sel) qa.push_back(int'(in_data));
                else        qb.push_back(int'(in_data));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (sent < 1000) check("rnd cycle budget", 32'(sent), 32'd1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_demux1to2.md
# stream_demux1to2

Registered 1-to-2 stream demultiplexer: the return-direction counterpart of the `mux2to1` datapath block. One input stream carries an N-bit word plus a `sel` tag; each accepted word is routed to output port A (`sel`=1) or port B (`sel`=0). Each port has its own 2-entry buffer, so a stalled port never corrupts the other port's traffic. It sits between a single producer and two independent consumers, all using valid/ready handshakes.

## Interface
- `N`, default 4: data word width in bits.
- `CW`, default 8: width of each delivered-word counter.
- `clk`  input  1  clock; all state updates on posedge.
- `rstN`  input  1  reset, asynchronous, active-low.
- `in_valid`  input  1  the producer has a word.
- `in_sel`  input  1  route tag: 1 selects port A, 0 selects port B.
- `in_data`  input  N  input word.
- `in_ready`  output  1  the block accepts the word this cycle.
- `a_valid`, `b_valid`  output  1 each  port holds a word.
- `a_ready`, `b_ready`  input  1 each  the consumer takes the word.
- `a`, `b`  output  N each  port head word.
- `a_count`, `b_count`  output  CW each  words delivered on each port, modulo 2^CW.

## Operation
- Input transfer occurs when `in_valid && in_ready` at posedge. Output transfer on A occurs when `a_valid && a_ready`; B is the same.
- `in_ready` = `in_sel ? !full_A : !full_B`.
  - It depends only on `in_sel` and registered full flags.
  - There is no combinational path from `a_ready`/`b_ready`.
  - `in_ready` is forced 0 while `rstN` is low.
- Each port buffer is a 2-entry FIFO with a registered head. Occupancy states are EMPTY(0), ONE(1), FULL(2).
  - EMPTY, push → ONE.
  - ONE, push only → FULL.
  - ONE, pop only → EMPTY.
  - ONE, push and pop → ONE; the new word becomes head next cycle.
  - FULL, pop → ONE; the second entry moves to head.
  - FULL, push is impossible because `in_ready` is 0.
- A full port that is popped in the same cycle still blocks input that cycle. No pass-through is permitted.
- `x_valid` = occupancy != EMPTY. `x` is the head register.
- Word order is preserved per port. No ordering is guaranteed between ports.
- `x_count` increments by 1 on each output transfer and wraps from 2^CW−1 to 0.
- `in_data`/`in_sel` are ignored when `in_valid` = 0.

## Timing
- Reset values (asynchronous, immediate on `rstN` falling):
  - `a_valid` = `b_valid` = 0.
  - `a` = `b` = 0.
  - `a_count` = `b_count` = 0.
  - Occupancy = EMPTY.
  - `in_ready` = 0 while in reset.
- First cycle after `rstN` rises: `in_ready` = 1.
- Latency: a word accepted at edge k has `x_valid` = 1 and the word on `x` after edge k (1 cycle).
- Throughput: 1 word/cycle sustained to one port when its consumer holds ready high.
- Once `x_valid` is 1, `x` and `x_valid` stay stable until the transfer completes.
- Reset mid-operation flushes both buffers; buffered words are lost and the counters clear.

## Structure
- Package `stream_pkg`:
  - `BUF_DEPTH` = 2.
  - Occupancy enum `occ_t` {EMPTY, ONE, FULL}.
  - Default `CW`.
- Sub-module `fifo2` (parameter N), instantiated twice, one per port.
  - Ports: `clk`, `rstN`, `push`, `din`, `pop`, `dout`, `valid`, `full`.
- The top level holds the routing, the `in_ready` logic and the counters.

## Test plan
All cases use N=4 unless noted.
- Reset: assert `rstN`=0 mid-cycle → `a_valid`, `b_valid`, counts and `in_ready` go to 0 immediately. Release → `in_ready` = 1 next cycle.
- Routing: send (sel=1, 4'hA), then (sel=0, 4'h5) with both readies high → `a` = A one cycle after the first transfer, `b` = 5 one cycle after the second, `a_count` = `b_count` = 1.
- Back-pressure: `a_ready` = 0, send 3 words (1,2,3) to A → first two accepted, `in_ready` = 0 on the third. Then `a_ready` = 1 → outputs 1, 2, 3 in order, `a_count` = 3.
- Port independence: A full and stalled, send B words 6 and 7 → both accepted and delivered, A unchanged.
- Full plus pop: A full, `a_ready` = 1 and `in_valid` to A in the same cycle → input not accepted that cycle, accepted the next cycle.
- Counter wrap: with CW=2, deliver 5 words on B → `b_count` = 1.
- Random: 1000 words with random sel and readies → per-port order and data match a scoreboard.
